mul_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8x8 sequential multiplier (load/valid style, 16-bit product) between NUM_REQ requesters. It accepts one operand pair at a time, pulses the multiplier's load, waits for its valid, and returns the product to the granted requester with a one-cycle done pulse. It sits between the client blocks and the single shared multiplier instance.

---
 rtl/mul_share_arbiter.sv | 132 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin arbiter/sequencer sharing one 8x8 sequential multiplier
//   Ports:
//     clk, reset_n            clock (rising edge), asynchronous active-low reset
//     req[NUM_REQ]            per-requester request, held with operands until grant
//     req_a/req_b             packed operands, requester i at [8i+7:8i]
//     grant[NUM_REQ]          one-hot one-cycle pulse: operands captured
//     done[NUM_REQ]           one-hot one-cycle pulse: result valid
//     result[16]              product for the requester flagged by done, held until next done
//     busy                    high whenever the sequencer is not idle
//     mul_load/mul_a/mul_b    load strobe and operands to the shared multiplier
//     mul_product/mul_valid   product and level-high completion flag from the multiplier
//   Optional: define MUL_TIMEOUT_EN to add the err output and a WAIT-state watchdog
//   that completes with result 16'hFFFF after TIMEOUT_CYCLES cycles without mul_valid.
module mul_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [15:0]          result,
  output logic                 busy,
  output logic                 mul_load,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_product,
  input  logic                 mul_valid
`ifdef MUL_TIMEOUT_EN
  ,
  output logic                 err
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
  state_t r_state;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_start, w_sel, w_idx;
  logic w_found;
  logic [7:0] w_a [NUM_REQ];
  logic [7:0] w_b [NUM_REQ];
`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
`endif
  if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mul_share_arbiter: inconsistent NUM_REQ/IDX_W/TIMEOUT_CYCLES");
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a[g] = req_a[8*g +: 8];
    assign w_b[g] = req_b[8*g +: 8];
  end
  // Search starts one past the last grant so the previous winner ends up lowest priority.
  assign w_start = (r_last == IDX_W'(NUM_REQ - 1)) ? '0 : r_last + 1'b1;
  always_comb begin
    w_sel   = w_start;
    w_found = 1'b0;
    w_idx   = w_start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
      w_idx = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_last   <= IDX_W'(NUM_REQ - 1);
      grant    <= '0;
      done     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      mul_load <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
`ifdef MUL_TIMEOUT_EN
      err      <= 1'b0;
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          grant    <= NUM_REQ'(1) << w_sel;
          mul_a    <= w_a[w_sel];
          mul_b    <= w_b[w_sel];
          mul_load <= 1'b1;
          r_last   <= w_sel;
          busy     <= 1'b1;
          r_state  <= LOAD;
        end
        // mul_valid may still show the previous operation's completion here, so it is not looked at.
        LOAD: begin
          grant    <= '0;
          mul_load <= 1'b0;
          r_state  <= WAIT;
`ifdef MUL_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end
        WAIT: if (mul_valid) begin
          result  <= mul_product;
          done    <= NUM_REQ'(1) << r_last;
          r_state <= RESP;
        end
`ifdef MUL_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result  <= 16'hFFFF;
          err     <= 1'b1;
          done    <= NUM_REQ'(1) << r_last;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
`endif
        RESP: begin
          done    <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
`ifdef MUL_TIMEOUT_EN
          err     <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed self-checking bench with a timestamp-based reference model
module tb_mul_share_arbiter;
  localparam int N  = 4;
  localparam int TO = 31;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [7:0] ra [N];
  logic [7:0] rb [N];
  logic [N*8-1:0] req_a, req_b;
  logic [N-1:0] grant, done;
  logic [15:0] result;
  logic busy, mul_load;
  logic [7:0] mul_a, mul_b;
  logic [15:0] mul_product = '0;
  logic mul_valid = 1'b0;
`ifdef MUL_TIMEOUT_EN
  logic err;
`endif
  assign req_a = {ra[3], ra[2], ra[1], ra[0]};
  assign req_b = {rb[3], rb[2], rb[1], rb[0]};
  always #5 clk = ~clk;
  mul_share_arbiter #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .done(done), .result(result), .busy(busy),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_valid(mul_valid)
`ifdef MUL_TIMEOUT_EN
    , .err(err)
`endif
  );
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Shared multiplier: captures operands on the edge that sees mul_load, clears valid then,
  // and raises valid lat cycles later unless hang is set.
  int lat = 3;
  int mcnt = 0;
  bit hang = 1'b0;
  bit ld_pend = 1'b0;
  logic [7:0] pa = '0, pb = '0;
  always @(posedge clk) begin
    #1;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0 && !hang) begin
        mul_valid = 1'b1;
        mul_product = {8'd0, pa} * {8'd0, pb};
      end
    end
    if (ld_pend) begin
      ld_pend = 1'b0;
      mul_valid = 1'b0;
      mcnt = lat;
      pa = mul_a;
      pb = mul_b;
    end
    if (mul_load) ld_pend = 1'b1;
  end
  // Reference model: edge-numbered timestamps. A grant may happen once the previous operation is
  // two edges past its done; done fires on the first edge at least two past the grant that sees
  // mul_valid high.
  int en = 0, m_owner = -1, m_last = N - 1, m_free = 0, m_gn = 0, pick = -1;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic [15:0] e_result = '0;
  logic e_busy = 1'b0, e_load = 1'b0, e_err = 1'b0;
  logic [7:0] e_a = '0, e_b = '0;
  always @(posedge clk) begin
    if (!reset_n) begin
      en = 0; m_owner = -1; m_last = N - 1; m_free = 0; m_gn = 0;
      e_grant = '0; e_done = '0; e_result = '0; e_busy = 1'b0;
      e_load = 1'b0; e_err = 1'b0; e_a = '0; e_b = '0;
    end else begin
      en++;
      e_grant = '0; e_load = 1'b0; e_done = '0; e_err = 1'b0;
      if (m_owner >= 0 && en >= m_gn + 2 && mul_valid) begin
        e_done = N'(1) << m_owner; e_result = mul_product; m_owner = -1; m_free = en + 2;
      end
`ifdef MUL_TIMEOUT_EN
      else if (m_owner >= 0 && en == m_gn + 1 + TO) begin
        e_done = N'(1) << m_owner; e_result = 16'hFFFF; e_err = 1'b1; m_owner = -1; m_free = en + 2;
      end
`endif
      else if (m_owner < 0 && en >= m_free && req != '0) begin
        pick = -1;
        for (int k = 0; k < N && pick < 0; k++)
          if (req[(m_last + 1 + k) % N]) pick = (m_last + 1 + k) % N;
        e_grant = N'(1) << pick; e_load = 1'b1; e_a = ra[pick]; e_b = rb[pick];
        m_last = pick; m_owner = pick; m_gn = en;
      end
      e_busy = (m_owner >= 0) || (e_done != '0);
    end
  end
  int g_idx[$], g_cyc[$], d_idx[$], d_cyc[$];
  logic [15:0] d_res[$];
  logic d_err[$];
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_grant", grant, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
      chk("rst_busy", busy, 0); chk("rst_load", mul_load, 0); chk("rst_a", mul_a, 0); chk("rst_b", mul_b, 0);
`ifdef MUL_TIMEOUT_EN
      chk("rst_err", err, 0);
`endif
    end else begin
      chk("grant", grant, e_grant); chk("done", done, e_done); chk("result", result, e_result);
      chk("busy", busy, e_busy); chk("mul_load", mul_load, e_load);
      chk("mul_a", mul_a, e_a); chk("mul_b", mul_b, e_b);
`ifdef MUL_TIMEOUT_EN
      chk("err", err, e_err);
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (grant[i] === 1'b1) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
      if (done[i] === 1'b1) begin
        d_idx.push_back(i); d_cyc.push_back(cyc); d_res.push_back(result);
`ifdef MUL_TIMEOUT_EN
        d_err.push_back(err);
`else
        d_err.push_back(1'b0);
`endif
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic clear_logs();
    g_idx.delete(); g_cyc.delete(); d_idx.delete(); d_cyc.delete(); d_res.delete(); d_err.delete();
  endtask
  task automatic wait_grants(input int n, input int budget);
    int c = 0;
    while (g_idx.size() < n && c < budget) begin tick(1); c++; end
    chk("grant_wait", 32'(g_idx.size() >= n), 1);
  endtask
  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin tick(1); c++; end
    chk("idle_wait", busy, 0);
  endtask
  task automatic one_op(input int idx, input logic [7:0] a, input logic [7:0] b, input int l);
    clear_logs();
    lat = l; ra[idx] = a; rb[idx] = b; req = N'(1) << idx;
    wait_grants(1, 20);
    req = '0;
    wait_idle(80);
    chk("op_cnt", d_idx.size(), 1);
    if (d_idx.size() == 1 && g_idx.size() == 1) begin
      chk("op_grant_idx", g_idx[0], idx);
      chk("op_done_idx", d_idx[0], idx);
    end
  endtask
  int exp_o[5] = '{0, 1, 2, 3, 0};
  logic [15:0] exp_r[4] = '{16'd21, 16'd200, 16'd132, 16'hFE01};
  int n1;
  initial begin
    ra[0] = 8'd3;   rb[0] = 8'd7;
    ra[1] = 8'd10;  rb[1] = 8'd20;
    ra[2] = 8'd12;  rb[2] = 8'd11;
    ra[3] = 8'd255; rb[3] = 8'd255;
    req = 4'b1111;
    tick(3);
    reset_n = 1'b1;
    wait_grants(5, 100);
    req = '0;
    wait_idle(80);
    if (g_idx.size() >= 5 && d_idx.size() >= 4) begin
      for (int i = 0; i < 5; i++) chk("fair_order", g_idx[i], exp_o[i]);
      for (int i = 0; i < 4; i++) begin
        chk("fair_done_idx", d_idx[i], i);
        chk("fair_res", d_res[i], exp_r[i]);
      end
    end
    one_op(2, 8'd12, 8'd11, 8);
    if (d_res.size() == 1) begin
      chk("single_res", d_res[0], 16'd132);
      chk("single_lat", d_cyc[0] - g_cyc[0], 10);
    end
    one_op(0, 8'd9, 8'd6, 4);
    if (d_res.size() == 1) begin
      chk("stale_res", d_res[0], 16'd54);
      chk("stale_lat", d_cyc[0] - g_cyc[0], 6);
    end
    clear_logs();
    lat = 10; ra[1] = 8'd7; rb[1] = 8'd9; req = 4'b0010;
    wait_grants(1, 20);
    ra[0] = 8'd2; rb[0] = 8'd2; req = 4'b0001;
    tick(4);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    wait_grants(2, 20);
    req = '0;
    wait_idle(80);
    n1 = 0;
    foreach (d_idx[i]) if (d_idx[i] == 1) n1++;
    chk("abort_no_done", n1, 0);
    chk("abort_done_cnt", d_idx.size(), 1);
    if (g_idx.size() >= 2 && d_res.size() == 1) begin
      chk("abort_regrant", g_idx[1], 0);
      chk("abort_res", d_res[0], 16'd4);
    end
`ifdef MUL_TIMEOUT_EN
    hang = 1'b1;
    one_op(2, 8'd5, 8'd5, 3);
    if (d_res.size() == 1) begin
      chk("to_res", d_res[0], 16'hFFFF);
      chk("to_err", d_err[0], 1);
      chk("to_lat", d_cyc[0] - g_cyc[0], TO + 1);
    end
    hang = 1'b0;
    one_op(3, 8'd255, 8'd255, 3);
    if (d_res.size() == 1) begin
      chk("after_to_res", d_res[0], 16'hFE01);
      chk("after_to_err", d_err[0], 0);
    end
`endif
    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1);
  end
endmodule
